// File: rtl/mips150_mem_stage_pkg.sv
// Shared MIPS150 codes: MemWrite/Mask encodings driven by the decoder, mem-stage FSM states, op record.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: memwrite_e, mask_e, mem_state_e, mem_op_t, and store/alignment helper functions.
package mips150_mem_stage_pkg;

    // Decoder MemWrite field: which store, if any.
    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_SB   = 2'b01,
        MW_SH   = 2'b10,
        MW_SW   = 2'b11
    } memwrite_e;

    // Decoder Mask field: load width and extension; only meaningful when MemtoReg=1.
    typedef enum logic [2:0] {
        MASK_LB  = 3'b000,
        MASK_LH  = 3'b001,
        MASK_LW  = 3'b010,
        MASK_LBU = 3'b011,
        MASK_LHU = 3'b100
    } mask_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } mem_state_e;

    // Memory op captured at accept and held until the op retires.
    typedef struct packed {
        logic [29:0] word;      // word address bits [31:2]
        logic [1:0]  off;       // byte offset inside the word
        logic [1:0]  memwrite;
        logic [2:0]  mask;
        logic        memtoreg;
        logic        regwrite;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } mem_op_t;

    // Big-endian byte enables: bit3 is lane 0 (data[31:24]).
    function automatic logic [3:0] store_we(input logic [1:0] mw, input logic [1:0] off);
        case (mw)
            MW_SB:   return 4'b1000 >> off;
            MW_SH:   return off[1] ? 4'b0011 : 4'b1100;
            MW_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the store data across lanes so the byte enables alone select the target.
    function automatic logic [31:0] store_wdata(input logic [1:0] mw, input logic [31:0] wdata);
        case (mw)
            MW_SB:   return {4{wdata[7:0]}};
            MW_SH:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // A load is classified by its mask and takes precedence over any store code.
    // Reserved mask codes are treated as word accesses.
    function automatic logic access_misaligned(input logic [1:0] mw, input logic memtoreg,
                                               input logic [2:0] mask, input logic [1:0] off);
        if (memtoreg) begin
            case (mask)
                MASK_LB, MASK_LBU: return 1'b0;
                MASK_LH, MASK_LHU: return off[0];
                default:           return |off;
            endcase
        end
        case (mw)
            MW_SH:   return off[0];
            MW_SW:   return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips150_mem_stage_if.sv
// Data-memory req/gnt/rvalid bus between the mem stage (master) and data memory (slave).
// Latency: n/a (wiring only).
// Backpressure: master holds req/addr/we/wdata until gnt; read data returns on rvalid.
//
// Signals: mem_req, mem_addr[31:0], mem_we[3:0], mem_wdata[31:0] (master out);
//          mem_gnt, mem_rvalid, mem_rdata[31:0] (slave out).
interface mips150_mem_stage_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mips150_load_align.sv
// Load extract: picks the addressed byte/halfword from a big-endian word and extends it.
// Latency: combinational.
// Backpressure: none.
//
// Ports: mask[2:0] load type, off[1:0] byte offset, rdata[31:0] memory word, data[31:0] extended result.
module mips150_load_align
    import mips150_mem_stage_pkg::*;
(
    input  logic [2:0]  mask,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Lane 0 is the most significant byte.
        case (off)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[15:0] : rdata[31:16];

        case (mask)
            MASK_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            MASK_LBU: data = {24'h000000, byte_sel};
            MASK_LH:  data = {{16{half_sel[15]}}, half_sel};
            MASK_LHU: data = {16'h0000, half_sel};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mips150_mem_stage.sv
// MIPS150 memory/writeback stage: stores with byte enables, aligned/extended loads, pass-through ALU ops.
// Latency: non-memory and misaligned ops 1 cycle; memory ops 1 cycle after gnt (store) or rvalid (load).
// Backpressure: in_ready drops while a memory op is outstanding; the writeback side cannot stall.
//
// Ports: clk, rst_n; in_valid/in_ready op handshake with in_alu, in_wdata, in_memwrite, in_mask,
//        in_memtoreg, in_regwrite, in_rd; mem (data-memory bus master); wb_valid/wb_we/wb_rd/wb_data
//        writeback beat; exc_misalign and exc_buserr one-cycle exception flags.
module mips150_mem_stage
    import mips150_mem_stage_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_alu,
    input  logic [31:0]                in_wdata,
    input  logic [1:0]                 in_memwrite,
    input  logic [2:0]                 in_mask,
    input  logic                       in_memtoreg,
    input  logic                       in_regwrite,
    input  logic [4:0]                 in_rd,

    mips150_mem_stage_if.master        mem,

    output logic                       wb_valid,
    output logic                       wb_we,
    output logic [4:0]                 wb_rd,
    output logic [31:0]                wb_data,
    output logic                       exc_misalign,
    output logic                       exc_buserr
);

    localparam int                 CNT_W      = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam bit                 TIMEOUT_EN = (WAIT_TIMEOUT != 0);
    // The counter is 0 in the first REQ cycle, so the last allowed cycle holds WAIT_TIMEOUT-1.
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'((WAIT_TIMEOUT > 0) ? (WAIT_TIMEOUT - 1) : 0);

    mem_state_e        state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              exc_misalign_q, exc_misalign_d;
    logic              exc_buserr_q, exc_buserr_d;

    logic              accept;
    logic              in_is_mem;
    logic              in_misalign;
    logic              op_done;
    logic              timeout_hit;
    logic              store_active;
    logic [31:0]       load_data;

    assign in_ready    = (state_q == ST_IDLE);
    assign accept      = in_valid & in_ready;
    assign in_is_mem   = in_memtoreg | (in_memwrite != MW_NONE);
    assign in_misalign = access_misaligned(in_memwrite, in_memtoreg, in_mask, in_alu[1:0]);
    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    // A store retires on gnt; a load retires on rvalid, which may coincide with gnt.
    always_comb begin
        op_done = 1'b0;
        case (state_q)
            ST_REQ:  op_done = mem.mem_gnt & (~op_q.memtoreg | mem.mem_rvalid);
            ST_WAIT: op_done = mem.mem_rvalid;
            default: op_done = 1'b0;
        endcase
    end

    // Bus fields come straight from the latched op, so they stay stable until gnt.
    assign store_active  = mem.mem_req & ~op_q.memtoreg;
    assign mem.mem_req   = (state_q == ST_REQ);
    assign mem.mem_addr  = mem.mem_req ? {op_q.word, 2'b00} : 32'h0;
    assign mem.mem_we    = store_active ? store_we(op_q.memwrite, op_q.off) : 4'b0000;
    assign mem.mem_wdata = store_active ? store_wdata(op_q.memwrite, op_q.wdata) : 32'h0;

    mips150_load_align u_load_align (
        .mask  (op_q.mask),
        .off   (op_q.off),
        .rdata (mem.mem_rdata),
        .data  (load_data)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        cnt_d          = cnt_q;
        wb_valid_d     = 1'b0;
        wb_we_d        = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        exc_misalign_d = 1'b0;
        exc_buserr_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!in_is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = in_regwrite;
                        wb_rd_d    = in_rd;
                        wb_data_d  = in_alu;
                    end else if (in_misalign) begin
                        wb_valid_d     = 1'b1;
                        wb_rd_d        = in_rd;
                        wb_data_d      = 32'h0;
                        exc_misalign_d = 1'b1;
                    end else begin
                        op_d = '{word:     in_alu[31:2],
                                 off:      in_alu[1:0],
                                 memwrite: in_memwrite,
                                 mask:     in_mask,
                                 memtoreg: in_memtoreg,
                                 regwrite: in_regwrite,
                                 rd:       in_rd,
                                 wdata:    in_wdata};
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end
                end
            end

            ST_REQ, ST_WAIT: begin
                if (op_done) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = op_q.rd;
                    if (op_q.memtoreg) begin
                        wb_we_d   = op_q.regwrite;
                        wb_data_d = load_data;
                    end else begin
                        wb_data_d = 32'h0;
                    end
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    // Completion wins over a timeout landing in the same cycle.
                    wb_valid_d   = 1'b1;
                    wb_rd_d      = op_q.rd;
                    wb_data_d    = 32'h0;
                    exc_buserr_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == ST_REQ && mem.mem_gnt) begin
                        state_d = ST_WAIT;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            cnt_q          <= '0;
            wb_valid_q     <= 1'b0;
            wb_we_q        <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= 32'h0;
            exc_misalign_q <= 1'b0;
            exc_buserr_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            cnt_q          <= cnt_d;
            wb_valid_q     <= wb_valid_d;
            wb_we_q        <= wb_we_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            exc_misalign_q <= exc_misalign_d;
            exc_buserr_q   <= exc_buserr_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_we        = wb_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign exc_misalign = exc_misalign_q;
    assign exc_buserr   = exc_buserr_q;

endmodule
